led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised LED pattern engine driving the board LED bank. Generalises the fill/drain
//  shifter to WIDTH LEDs, adds a programmable step-rate prescaler, four selectable
//  patterns, a valid/ready mode-change handshake, and pause/single-step. Sits between
//  top-level control (switches/CSR) and the led pins.
// PARAMETERS
//  WIDTH       16  number of LEDs; must be >= 2
//  PRESCALE_W  24  width of the prescaler counter and of div
// PORTS
//  clk         in   1           clock
//  rst         in   1           synchronous reset, active-high
//  en          in   1           1 = free-run at prescaler rate; 0 = paused
//  div         in   PRESCALE_W  pattern advances every div+1 cycles
//  step        in   1           one-cycle pulse; advances one pattern step (only while en=0)
//  mode_i      in   2           requested mode (led_mode_t)
//  mode_valid  in   1           mode request valid
//  mode_ready  out  1           mode request can be accepted
//  mode_o      out  2           currently active mode
//  tick_o      out  1           1-cycle pulse on each prescaler expiry
//  led         out  WIDTH       LED pattern, registered
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): led=0, mode_o=FILL, dir=LEFT, cnt=0, state=RUN,
//   tick_o=0, mode_ready=1. rst overrides every other input.
//  Prescaler: cnt increments while en=1. When cnt>=div: tick_o=1 next cycle, cnt<=0.
//   cnt>=div (not ==) so lowering div mid-count expires at once. div=0 -> tick every cycle.
//   en=0: cnt holds and no tick is produced.
//  Advance: on a registered tick with en=1, or on step=1 with en=0. step is ignored when en=1.
//  Patterns (one advance):
//   FILL   : led[W-1]==0 ? (led<<1)|1 : led<<1. Period 2*WIDTH. Seed 0.
//   ROTATE : {led[W-2:0],led[W-1]}. Seed 1. If led==0, load 1.
//   BOUNCE : single lit bit. LEFT: led[W-1] ? (dir<=RIGHT, led>>1) : led<<1.
//            RIGHT: led[0] ? (dir<=LEFT, led<<1) : led>>1. Period 2*WIDTH-2. Seed 1, LEFT.
//   COUNT  : led+1 modulo 2^WIDTH, wraps to 0. Seed 0.
//  Mode FSM (states RUN, LOAD):
//   RUN : mode_ready=1. On mode_valid&&mode_ready: mode_o<=mode_i, led<=seed(mode_i),
//         dir<=LEFT, cnt<=0, go to LOAD. Re-selecting the current mode also reseeds.
//   LOAD: mode_ready=0, no advance, no tick; back to RUN next cycle.
//   Accept and advance in the same cycle: accept wins and the advance is dropped.
//  Step-to-led latency: 1 cycle. Tick-to-led latency: 1 cycle after tick_o.
//  rst in LOAD or mid-count: returns to the reset values above on the next edge.
// STRUCTURE
//  Shared package led_pkg: typedef enum logic[1:0] led_mode_t {FILL,ROTATE,BOUNCE,COUNT};
//   typedef enum logic led_state_t {RUN,LOAD}; typedef enum logic led_dir_t {LEFT,RIGHT}.
//  Sub-module led_prescaler (clk, rst, en, div, clr -> tick): counter and tick only.
//  Top: mode FSM, next-pattern combinational case, led register.
// TESTING
//  1 WIDTH=4, FILL, div=0, en=1 -> led 0001,0011,0111,1111,1110,1100,1000,0000,0001.
//  2 BOUNCE, WIDTH=4, div=0 -> 0001,0010,0100,1000,0100,0010,0001,0010; dir flips at ends.
//  3 COUNT, WIDTH=4, div=2 -> tick_o every 3rd cycle; led 1110,1111,0000 wraps.
//  4 en=0, step pulses x3 in ROTATE -> 0010,0100,1000. Same step pulses with en=1: no extra advance.
//  5 mode_valid with ROTATE in the same cycle as a tick -> led=0001, mode_ready=0 for
//    1 cycle, tick dropped.
//  6 rst=1 during LOAD and mid-count -> led=0, mode_o=FILL, mode_ready=1, tick_o=0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the LED pattern engine.
//   led_mode_t  : selectable LED pattern
//   led_state_t : mode-change FSM state
//   led_dir_t   : travel direction of the BOUNCE pattern
package led_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ROTATE = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } led_mode_t;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } led_state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } led_dir_t;

  // Every pattern seeds either all-off or only LED 0 lit, so the seed is
  // fully described by its bit 0.
  function automatic logic seed_lsb(led_mode_t m);
    return (m == ROTATE) || (m == BOUNCE);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler for the LED pattern engine.
//   clk  in  clock
//   rst  in  synchronous reset, active-high
//   en   in  count enable; counter holds and no tick is produced while low
//   div  in  tick period is div+1 cycles
//   clr  in  synchronous clear of counter and pending tick
//   tick out registered one-cycle pulse on each expiry
module led_prescaler #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  clr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // >= rather than == so that lowering div below the running count
  // expires immediately instead of waiting for a full wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt >= div) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: WIDTH LEDs, programmable step rate, four patterns,
// valid/ready mode change, pause and single-step.
//   clk        in  clock
//   rst        in  synchronous reset, active-high
//   en         in  1 = free-run at prescaler rate, 0 = paused
//   div        in  pattern advances every div+1 cycles
//   step       in  single advance pulse, honoured only while en=0
//   mode_i     in  requested mode
//   mode_valid in  mode request valid
//   mode_ready out mode request can be accepted
//   mode_o     out active mode
//   tick_o     out prescaler expiry pulse
//   led        out registered LED pattern
//
// state | meaning
// RUN   | patterns advance, mode requests accepted
// LOAD  | one cycle after a mode change: seed settles, no tick, no advance
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  step,
  input  led_mode_t             mode_i,
  input  logic                  mode_valid,
  output logic                  mode_ready,
  output led_mode_t             mode_o,
  output logic                  tick_o,
  output logic [WIDTH-1:0]      led
);

  led_state_t       state_q, state_nxt;
  led_mode_t        mode_nxt;
  led_dir_t         dir_q, dir_nxt, pat_dir;
  logic [WIDTH-1:0] led_nxt, pat_led;
  logic             accept, advance, clr;

  led_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .div  (div),
    .clr  (clr),
    .tick (tick_o)
  );

  // One advance of the active pattern.
  always_comb begin
    pat_led = led;
    pat_dir = dir_q;
    case (mode_o)
      FILL:   pat_led = led[WIDTH-1] ? (led << 1) : ((led << 1) | WIDTH'(1));
      ROTATE: pat_led = (led == '0) ? WIDTH'(1) : {led[WIDTH-2:0], led[WIDTH-1]};
      BOUNCE: begin
        if (dir_q == LEFT) begin
          if (led[WIDTH-1]) begin
            pat_dir = RIGHT;
            pat_led = led >> 1;
          end else begin
            pat_led = led << 1;
          end
        end else begin
          if (led[0]) begin
            pat_dir = LEFT;
            pat_led = led << 1;
          end else begin
            pat_led = led >> 1;
          end
        end
      end
      COUNT:  pat_led = led + 1'b1;
      default: pat_led = led;
    endcase
  end

  always_comb begin
    state_nxt  = state_q;
    mode_nxt   = mode_o;
    led_nxt    = led;
    dir_nxt    = dir_q;
    mode_ready = (state_q == RUN);
    accept     = mode_valid && mode_ready;
    advance    = (state_q == RUN) && (en ? tick_o : step);
    // Clearing the prescaler on accept and through LOAD drops any tick
    // coincident with the mode change and restarts the rate from zero.
    clr        = accept || (state_q == LOAD);
    case (state_q)
      RUN: begin
        if (accept) begin
          mode_nxt  = mode_i;
          led_nxt   = WIDTH'(seed_lsb(mode_i));
          dir_nxt   = LEFT;
          state_nxt = LOAD;
        end else if (advance) begin
          led_nxt = pat_led;
          dir_nxt = pat_dir;
        end
      end
      LOAD:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      mode_o  <= FILL;
      dir_q   <= LEFT;
      led     <= '0;
    end else begin
      state_q <= state_nxt;
      mode_o  <= mode_nxt;
      dir_q   <= dir_nxt;
      led     <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
  import led_pkg::*;

  localparam int W  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [PW-1:0] div = '0;
  logic          step = 1'b0;
  led_mode_t     mode_i = FILL;
  logic          mode_valid = 1'b0;
  logic          mode_ready;
  led_mode_t     mode_o;
  logic          tick_o;
  logic [W-1:0]  led;

  led_pattern_gen #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .step(step),
    .mode_i(mode_i), .mode_valid(mode_valid), .mode_ready(mode_ready),
    .mode_o(mode_o), .tick_o(tick_o), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int led;
    int mode;
    int tick;
    int ready;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: pattern position k within the mode's cycle.
  int m_cnt = 0, m_tick = 0, m_load = 0, m_mode = 0, m_k = 0;

  function automatic int period(int m);
    case (m)
      0: return 2 * W;
      1: return W;
      2: return 2 * W - 2;
      default: return 1 << W;
    endcase
  endfunction

  function automatic int pattern(int m, int k);
    int full;
    full = (1 << W) - 1;
    case (m)
      0: return (k <= W) ? ((1 << k) - 1) : (full & ~((1 << (k - W)) - 1));
      1: return 1 << k;
      2: return (k < W) ? (1 << k) : (1 << (2 * W - 2 - k));
      default: return k;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and push the expected post-edge outputs.
  task automatic cyc(input bit r, input bit e, input int d, input bit s,
                     input bit mv, input int mi);
    bit acc, adv;
    exp_t x;
    @(negedge clk);
    rst = r; en = e; div = PW'(d); step = s; mode_valid = mv; mode_i = led_mode_t'(mi);
    if (r) begin
      m_cnt = 0; m_tick = 0; m_load = 0; m_mode = 0; m_k = 0;
    end else begin
      acc = mv && !m_load;
      adv = !m_load && (e ? (m_tick != 0) : s);
      if (acc || m_load) begin
        m_cnt = 0; m_tick = 0;
      end else if (e) begin
        if (m_cnt >= d) begin m_cnt = 0; m_tick = 1; end
        else begin m_cnt++; m_tick = 0; end
      end else begin
        m_tick = 0;
      end
      if (acc) begin
        m_mode = mi; m_k = 0; m_load = 1;
      end else begin
        m_load = 0;
        if (adv) m_k = (m_k + 1) % period(m_mode);
      end
    end
    x.led = pattern(m_mode, m_k);
    x.mode = m_mode;
    x.tick = m_tick;
    x.ready = !m_load;
    q.push_back(x);
  endtask

  // Monitor: one expectation per clock, compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("led", int'(led), x.led);
        check("mode_o", int'(mode_o), x.mode);
        check("tick_o", int'(tick_o), x.tick);
        check("mode_ready", int'(mode_ready), x.ready);
      end
    end
  end

  initial begin
    int d;
    // reset
    repeat (2) cyc(1, 0, 0, 0, 0, 0);
    // FILL, div=0
    repeat (12) cyc(0, 1, 0, 0, 0, 0);
    // BOUNCE, div=0
    cyc(0, 1, 0, 0, 1, 2);
    repeat (12) cyc(0, 1, 0, 0, 0, 0);
    // COUNT, div=2, through the wrap
    cyc(0, 1, 2, 0, 1, 3);
    repeat (60) cyc(0, 1, 2, 0, 0, 0);
    // ROTATE, paused single-step
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) begin cyc(0, 0, 3, 1, 0, 0); cyc(0, 0, 3, 0, 0, 0); end
    // steps while free-running are ignored
    repeat (4) begin cyc(0, 1, 3, 1, 0, 0); cyc(0, 1, 3, 0, 0, 0); end
    // mode change coincident with a tick
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    // reset during LOAD
    cyc(0, 1, 0, 0, 1, 2);
    cyc(1, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    // reset mid-count, then lowering div mid-count
    repeat (3) cyc(0, 1, 5, 0, 0, 0);
    cyc(1, 1, 5, 0, 0, 0);
    repeat (4) cyc(0, 1, 6, 0, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 0, 0);
    // randomized traffic
    d = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 4);
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) != 0,
          d,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
